// File: rtl/divu.sv
// divu: multi-cycle unsigned WIDTH/WIDTH divider, radix-2 restoring, one
// quotient bit per clock. Produces quotient (LO) and remainder (HI) with a
// fixed WIDTH-cycle stall, including the divide-by-zero case.
module divu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Counter wide enough to index WIDTH iterations (at least one bit).
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;        // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;        // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dsr_q, dsr_d;        // captured divisor
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    // Datapath for one restoring step.
    logic [WIDTH:0]   shifted_s;           // {rem, next dividend bit}, can reach WIDTH+1 bits
    logic [WIDTH:0]   trial_s;
    logic             borrow_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic             last_step_s;
    logic             accept_s;

    // One restoring iteration: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        shifted_s             = {rem_q, quo_q[WIDTH-1]};
        {borrow_s, trial_s}   = {1'b0, shifted_s} - {2'b00, dsr_q};
        if (borrow_s) begin
            rem_next_s = shifted_s[WIDTH-1:0];
        end else begin
            rem_next_s = trial_s[WIDTH-1:0];
        end
        quo_next_s = {quo_q[WIDTH-2:0], ~borrow_s};
    end

    // Start is taken when idle, or on the final iteration edge for back-to-back issue.
    always_comb begin
        last_step_s = (state_q == S_RUN) && (count_q == LAST_C);
        if (state_q == S_IDLE) begin
            accept_s = start;
        end else begin
            accept_s = start && last_step_s;
        end
    end

    // Next-state and register updates for the IDLE/RUN controller.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_RUN: begin
                rem_d = rem_next_s;
                quo_d = quo_next_s;
                if (last_step_s) begin
                    done_d      = 1'b1;
                    quotient_d  = quo_next_s;
                    remainder_d = rem_next_s;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    count_d = count_q + ONE_C;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A newly accepted operation overrides the completion bookkeeping above,
        // but leaves the just-produced results and done pulse in place.
        if (accept_s) begin
            state_d = S_RUN;
            count_d = {CW{1'b0}};
            rem_d   = {WIDTH{1'b0}};
            quo_d   = dividend;
            dsr_d   = divisor;
            busy_d  = 1'b1;
            dbz_d   = (divisor == {WIDTH{1'b0}});
        end else begin
            dsr_d = dsr_q;
        end
    end

    // State and datapath registers with asynchronous reset; aborts any run in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= {CW{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            dsr_q       <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
